// File: rtl/difficulty_pkg.sv
// Shared types and constants for the front-panel difficulty selector.
package difficulty_pkg;

  typedef enum logic {
    BROWSE   = 1'b0,
    SELECTED = 1'b1
  } state_t;

  localparam int LEVEL_W = 2;

  localparam logic [LEVEL_W-1:0] LEVEL_EASY   = 2'd0;
  localparam logic [LEVEL_W-1:0] LEVEL_MEDIUM = 2'd1;
  localparam logic [LEVEL_W-1:0] LEVEL_HARD   = 2'd2;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push-button and emits a
// single-cycle pulse when a debounced press (stable 1 -> 0) is accepted.
// A press is only accepted once the key has been seen released after reset,
// so a button held through reset never produces a spurious press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [1:0]       valid_q, valid_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Next-state for synchronizer, debounce counter, arming and edge detect.
  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    valid_d      = {valid_q[0], 1'b1};
    // valid_q[1] marks that sync2_q now carries a real post-reset sample.
    armed_d      = armed_q | (valid_q[1] & stable_q & sync2_q);
    press_d      = armed_q & stable_dly_q & ~stable_q;

    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // This cycle is the DEBOUNCE_CYCLES-th consecutive differing sample.
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; keys reset to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      valid_q      <= 2'b00;
      armed_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      valid_q      <= valid_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/difficulty_selector.sv
// Difficulty selection stage: two debounced keys cycle and confirm a level;
// a software game_over strobe releases the selection for a new round.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   BROWSE   | next press advances level (wrapping), confirm locks it
//   SELECTED | level frozen, presses ignored, game_over returns to BROWSE
module difficulty_selector
  import difficulty_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_LEVELS      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_next_n,
  input  logic               key_confirm_n,
  input  logic               game_over,
  output logic               difficulty_selected,
  output logic [LEVEL_W-1:0] difficulty_level,
  output logic               press_next,
  output logic               press_confirm
);

  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(NUM_LEVELS - 1);

  state_t             state_q, state_d;
  logic               selected_q, selected_d;
  logic [LEVEL_W-1:0] level_q, level_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_next_n),
    .press   (press_next)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm_db (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_confirm_n),
    .press   (press_confirm)
  );

  // Next-state, level and selection flag; confirm has priority over next.
  always_comb begin
    state_d    = state_q;
    selected_d = selected_q;
    level_d    = level_q;
    case (state_q)
      BROWSE: begin
        if (press_confirm) begin
          state_d    = SELECTED;
          selected_d = 1'b1;
        end else if (press_next) begin
          level_d = (level_q == LEVEL_TOP) ? LEVEL_EASY : level_q + LEVEL_W'(1);
        end
      end
      SELECTED: begin
        if (game_over) begin
          state_d    = BROWSE;
          selected_d = 1'b0;
        end
      end
      default: state_d = BROWSE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BROWSE;
      selected_q <= 1'b0;
      level_q    <= LEVEL_EASY;
    end else begin
      state_q    <= state_d;
      selected_q <= selected_d;
      level_q    <= level_d;
    end
  end

  assign difficulty_selected = selected_q;
  assign difficulty_level    = level_q;

endmodule

// File: tb/tb_difficulty_selector.sv
// Bench for difficulty_selector with a sample-history reference model.
module tb_difficulty_selector;

  localparam int D  = 4;
  localparam int NL = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_confirm_n = 1'b1;
  logic       game_over = 1'b0;
  logic       difficulty_selected;
  logic [1:0] difficulty_level;
  logic       press_next;
  logic       press_confirm;

  difficulty_selector #(.DEBOUNCE_CYCLES(D), .NUM_LEVELS(NL)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .key_next_n          (key_next_n),
    .key_confirm_n       (key_confirm_n),
    .game_over           (game_over),
    .difficulty_selected (difficulty_selected),
    .difficulty_level    (difficulty_level),
    .press_next          (press_next),
    .press_confirm       (press_confirm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pn_count = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Key samples taken at each edge are kept newest-first;
  // the debounced level flips once the D samples the synchronizer has
  // delivered (two edges old and older) all disagree with it. A press is the
  // cycle after a 1->0 flip, provided the key was seen released after reset.
  bit mh [2][D+2];
  bit m_stable [2];
  bit m_fell   [2];
  bit m_armed  [2];
  bit m_press  [2];
  bit m_sel;
  int m_level;
  int m_k;
  bit raw_v [2];
  bit all_diff;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < D + 2; j++) mh[i][j] = 1'b1;
          m_stable[i] = 1'b1;
          m_fell[i]   = 1'b0;
          m_armed[i]  = 1'b0;
          m_press[i]  = 1'b0;
        end
        m_sel   = 1'b0;
        m_level = 0;
        m_k     = 0;
      end else begin
        raw_v[0] = key_next_n;
        raw_v[1] = key_confirm_n;
        m_k++;
        if (m_sel) begin
          if (game_over) m_sel = 1'b0;
        end else if (m_press[1]) begin
          m_sel = 1'b1;
        end else if (m_press[0]) begin
          m_level = (m_level + 1) % NL;
        end
        for (int i = 0; i < 2; i++) begin
          m_press[i] = m_fell[i] && m_armed[i];
          if (m_k >= 3 && mh[i][1] && m_stable[i]) m_armed[i] = 1'b1;
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++) if (mh[i][j] == m_stable[i]) all_diff = 1'b0;
          m_fell[i] = all_diff && m_stable[i];
          if (all_diff) m_stable[i] = ~m_stable[i];
          for (int j = D + 1; j >= 1; j--) mh[i][j] = mh[i][j-1];
          mh[i][0] = raw_v[i];
        end
      end
    end
  end

  // Compare DUT against the model every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      check("selected", difficulty_selected, m_sel);
      check("level", difficulty_level, m_level);
      check("press_next", press_next, m_press[0]);
      check("press_confirm", press_confirm, m_press[1]);
      if (press_next) pn_count++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    cycles(2);
    #2 reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic press_keys(input bit nx, input bit cf, input int hold);
    @(negedge clk);
    key_next_n    = ~nx;
    key_confirm_n = ~cf;
    cycles(hold);
    key_next_n    = 1'b1;
    key_confirm_n = 1'b1;
    cycles(12);
  endtask

  int base;

  initial begin
    // Reset with next held: nothing may come out of it.
    key_next_n = 1'b0;
    cycles(3);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("reset_selected", difficulty_selected, 0);
    check("reset_level", difficulty_level, 0);
    check("reset_press", press_next | press_confirm, 0);
    base = pn_count;
    cycles(20);
    check("reset_no_press", pn_count - base, 0);
    key_next_n = 1'b1;
    cycles(12);

    // Bounce rejection, then one clean long press.
    base = pn_count;
    for (int r = 0; r < 5; r++) begin
      key_next_n = 1'b0;
      cycles(3);
      key_next_n = 1'b1;
      cycles(2);
    end
    cycles(4);
    check("bounce_no_press", pn_count - base, 0);
    key_next_n = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check("bounce_press_timing", press_next, int'(n == 7));
      if (n == 8) check("bounce_level", difficulty_level, 1);
    end
    key_next_n = 1'b1;
    cycles(12);

    // Wrap 1, 2, 0 from a fresh reset.
    do_reset();
    press_keys(1, 0, 8); check("wrap_1", difficulty_level, 1);
    press_keys(1, 0, 8); check("wrap_2", difficulty_level, 2);
    press_keys(1, 0, 8); check("wrap_0", difficulty_level, 0);

    // Confirm at level 2, then presses are ignored.
    press_keys(1, 0, 8);
    press_keys(1, 0, 8);
    press_keys(0, 1, 8);
    check("confirm_sel", difficulty_selected, 1);
    check("confirm_level", difficulty_level, 2);
    press_keys(1, 0, 8);
    press_keys(0, 1, 8);
    check("frozen_sel", difficulty_selected, 1);
    check("frozen_level", difficulty_level, 2);

    // game_over alone.
    @(negedge clk); game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("go_sel", difficulty_selected, 0);
    check("go_level", difficulty_level, 2);
    press_keys(1, 0, 8); check("after_go_wrap", difficulty_level, 0);
    press_keys(1, 0, 8); check("after_go_1", difficulty_level, 1);

    // Simultaneous next and confirm at level 1: confirm wins.
    press_keys(1, 1, 8);
    check("simul_sel", difficulty_selected, 1);
    check("simul_level", difficulty_level, 1);

    // game_over coincident with press_next.
    @(negedge clk); key_next_n = 1'b0;
    cycles(7);
    check("coinc_press_seen", press_next, 1);
    game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
    check("coinc_sel", difficulty_selected, 0);
    check("coinc_level", difficulty_level, 1);
    key_next_n = 1'b1;
    cycles(12);
    check("coinc_no_carry", difficulty_level, 1);
    press_keys(1, 0, 8); check("coinc_next", difficulty_level, 2);

    // Randomized bouncy keys and strobes, checked by the model each cycle.
    for (int s = 0; s < 400; s++) begin
      @(negedge clk);
      key_next_n    = ($urandom_range(0, 1) == 1);
      key_confirm_n = ($urandom_range(0, 2) != 0);
      game_over     = ($urandom_range(0, 7) == 0);
      if (s == 200) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
      cycles($urandom_range(0, 9));
      game_over = 1'b0;
    end
    key_next_n    = 1'b1;
    key_confirm_n = 1'b1;
    cycles(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
